// File: rtl/adc_serial_pkg.sv
// -----------------------------------------------------------------------------
// adc_serial_pkg
// Shared types and defaults for the serial ADC emulator (adc_serial_tx).
//   - mode_e       : sample-source selection (stream / fixed pattern / ramp)
//   - state_e      : transmitter FSM state, exposed as a typed enum so it can
//                    be probed by name
//   - DEF_*        : default geometry and pattern words
//   - fclk_high_len: number of bit times the frame clock stays high per frame
// -----------------------------------------------------------------------------
package adc_serial_pkg;

  localparam int          DEF_LANES      = 8;
  localparam int          DEF_BITS       = 12;
  localparam logic [11:0] DEF_IDLE_WORD  = 12'h800;  // mid-scale, sent on underrun
  localparam logic [11:0] DEF_FIXED_WORD = 12'hA5C;  // fixed-pattern word

  // Encoding 3 is reserved and behaves like the fixed pattern.
  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_FIXED  = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Frame clock is high for the first half of every frame.
  function automatic int fclk_high_len(input int bits);
    return bits / 2;
  endfunction

  localparam int DEF_FCLK_HIGH = DEF_BITS / 2;

endpackage

// File: rtl/adc_serial_tx_lane.sv
// -----------------------------------------------------------------------------
// adc_lane_serializer
// One serial lane: BITS-wide parallel-load shift register, MSB first.
// The output is the register MSB, so it is registered by construction.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_word (highest priority)
//   i_clear        : zero the register (transmitter disabled)
//   i_shift        : shift left one bit, zero fill
//   i_word         : parallel word for this lane
//   o_ser          : serial data out (current MSB)
// -----------------------------------------------------------------------------
module adc_lane_serializer #(
  parameter int BITS = 12
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic            i_shift,
  input  logic [BITS-1:0] i_word,
  output logic            o_ser
);

  logic [BITS-1:0] r_sh;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_word;
    end else if (i_clear) begin
      r_sh <= '0;
    end else if (i_shift) begin
      r_sh <= {r_sh[BITS-2:0], 1'b0};
    end
  end

  assign o_ser = r_sh[BITS-1];

endmodule

// File: rtl/adc_serial_tx.sv
// -----------------------------------------------------------------------------
// adc_serial_tx
// On-chip ADC emulator: serializes one BITS-wide word per lane per frame onto
// LANES serial lanes (one bit per aclk, MSB first) with an aligned frame clock.
// Ports:
//   aclk, aresetn  : clock, asynchronous active-low reset
//   en             : transmitter enable (dropping it abandons the frame)
//   mode           : 0 stream, 1 fixed, 2 ramp, 3 reserved (= fixed)
//   sync_req       : restart framing this cycle (only while en)
//   s_tdata/tvalid : stream source, lane k = s_tdata[k*BITS +: BITS]
//   s_tready       : combinational; high exactly on a stream-mode load cycle
//   ser_d          : serial lanes, registered
//   ser_fclk       : frame clock, high for the first BITS/2 bits of a frame
//   frame_cnt      : frames started since reset (wraps)
//   underrun       : sticky, a stream frame started without s_tvalid
//   underrun_clr   : clears underrun (a simultaneous new underrun wins)
// Valid/ready: a word is consumed on a cycle where s_tvalid && s_tready; its
// MSB appears on ser_d the next cycle and its LSB BITS cycles after accept.
// -----------------------------------------------------------------------------
module adc_serial_tx
  import adc_serial_pkg::*;
#(
  parameter int              LANES      = DEF_LANES,
  parameter int              BITS       = DEF_BITS,
  parameter logic [BITS-1:0] IDLE_WORD  = DEF_IDLE_WORD,
  parameter logic [BITS-1:0] FIXED_WORD = DEF_FIXED_WORD
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  sync_req,
  input  logic [LANES*BITS-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [LANES-1:0]      ser_d,
  output logic                  ser_fclk,
  output logic [31:0]           frame_cnt,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int CW        = $clog2(BITS);
  localparam int FCLK_HIGH = fclk_high_len(BITS);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_bit_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic [BITS-1:0] r_ramp;
  logic [31:0]     r_frame_cnt;
  logic            r_underrun;
  logic            r_fclk;
  logic            w_last_bit;
  logic            w_load;
  logic            w_shift;
  logic            w_clear;
  mode_e           w_mode;
  logic [BITS-1:0] w_word [LANES];

  assign w_mode = mode_e'(mode);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else if (w_load) begin
      w_state_nxt = ST_RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  // load is gated by aresetn so no word is ever handshaken while in reset.
  always_comb begin
    w_last_bit = (r_state == ST_RUN) && (r_bit_cnt == CW'(BITS - 1));
    w_load     = aresetn && en && ((r_state == ST_IDLE) || w_last_bit || sync_req);
    w_shift    = en && (r_state == ST_RUN) && !w_load;
    w_clear    = !en;
    s_tready   = w_load && (w_mode == MODE_STREAM);
  end

  // ---------------- word select (used only on load) ----------------
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_word[k] = FIXED_WORD;
      case (w_mode)
        MODE_STREAM: w_word[k] = s_tvalid ? s_tdata[k*BITS +: BITS] : IDLE_WORD;
        MODE_RAMP:   w_word[k] = r_ramp + BITS'(k);
        default:     w_word[k] = FIXED_WORD;
      endcase
    end
  end

  // A shift only happens below the last bit, so the increment never overflows.
  assign w_cnt_inc = r_bit_cnt + CW'(1);

  // ---------------- counters, frame clock, flags ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bit_cnt   <= '0;
      r_fclk      <= 1'b0;
      r_frame_cnt <= '0;
      r_ramp      <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_load) begin
        r_bit_cnt   <= '0;
        r_fclk      <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 32'd1;
        if (w_mode == MODE_RAMP) begin
          r_ramp <= r_ramp + BITS'(1);
        end
      end else if (w_shift) begin
        r_bit_cnt <= w_cnt_inc;
        r_fclk    <= (w_cnt_inc < CW'(FCLK_HIGH));
      end else begin
        r_bit_cnt <= '0;
        r_fclk    <= 1'b0;
      end

      if (w_load && (w_mode == MODE_STREAM) && !s_tvalid) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  // ---------------- lane serializers ----------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    adc_lane_serializer #(
      .BITS(BITS)
    ) u_lane (
      .i_clk  (aclk),
      .i_rst_n(aresetn),
      .i_load (w_load),
      .i_clear(w_clear),
      .i_shift(w_shift),
      .i_word (w_word[k]),
      .o_ser  (ser_d[k])
    );
  end

  assign ser_fclk  = r_fclk;
  assign frame_cnt = r_frame_cnt;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_adc_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_adc_serial_tx
// Bench for adc_serial_tx: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a frame-level model.
// -----------------------------------------------------------------------------
module tb_adc_serial_tx;
  import adc_serial_pkg::*;

  localparam int LANES = 8;
  localparam int BITS  = 12;
  localparam int W     = LANES * BITS;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          aresetn;
  logic          en;
  logic [1:0]    mode;
  logic          sync_req;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [LANES-1:0] ser_d;
  logic          ser_fclk;
  logic [31:0]   frame_cnt;
  logic          underrun;
  logic          underrun_clr;

  adc_serial_tx #(.LANES(LANES), .BITS(BITS)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .en          (en),
    .mode        (mode),
    .sync_req    (sync_req),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .ser_d       (ser_d),
    .ser_fclk    (ser_fclk),
    .frame_cnt   (frame_cnt),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level model ----------------
  // A frame is "the words chosen at its start" plus "how many bits in we are".
  logic            m_active;
  int              m_pos;
  logic [BITS-1:0] m_words [LANES];
  logic [31:0]     m_frames;
  logic            m_underrun;
  int              m_ramp;
  logic            m_load;

  assign m_load = aresetn && en && (!m_active || (m_pos == BITS - 1) || sync_req);

  function automatic logic [BITS-1:0] pick(input int k);
    if (mode == 2'd0) return s_tvalid ? s_tdata[k*BITS +: BITS] : 12'h800;
    if (mode == 2'd2) return 12'((m_ramp + k) % 4096);
    return 12'hA5C;
  endfunction

  function automatic logic [LANES-1:0] exp_ser();
    logic [LANES-1:0] v;
    v = '0;
    if (m_active)
      for (int k = 0; k < LANES; k++) v[k] = m_words[k][BITS-1-m_pos];
    return v;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_active   <= 1'b0;
      m_pos      <= 0;
      m_frames   <= '0;
      m_underrun <= 1'b0;
      m_ramp     <= 0;
      for (int k = 0; k < LANES; k++) m_words[k] <= '0;
    end else begin
      if (m_load) begin
        for (int k = 0; k < LANES; k++) m_words[k] <= pick(k);
        m_active <= 1'b1;
        m_pos    <= 0;
        m_frames <= m_frames + 32'd1;
        if (mode == 2'd2) m_ramp <= (m_ramp + 1) % 4096;
      end else if (!en) begin
        m_active <= 1'b0;
        m_pos    <= 0;
      end else if (m_active) begin
        m_pos <= m_pos + 1;
      end
      if (m_load && (mode == 2'd0) && !s_tvalid) m_underrun <= 1'b1;
      else if (underrun_clr)                     m_underrun <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    if (cmp_en) begin
      chk("m_ser_d",     ser_d,     exp_ser());
      chk("m_ser_fclk",  ser_fclk,  m_active && (m_pos < BITS / 2));
      chk("m_frame_cnt", frame_cnt, m_frames);
      chk("m_underrun",  underrun,  m_underrun);
      chk("m_s_tready",  s_tready,  m_load && (mode == 2'd0));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive_edge();
    @(posedge aclk);
    #2;
  endtask

  // Advance until the model says the current frame is at bit position p.
  task automatic wait_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 4 * BITS && !hit; n++) begin
      drive_edge();
      if (m_active && (m_pos == p)) hit = 1'b1;
    end
    chk("wait_pos_timeout", hit, 1'b1);
  endtask

  // Gather one whole frame from the lanes; starts at the first bit's negedge.
  task automatic collect(output logic [W-1:0] w);
    w = '0;
    for (int i = 0; i < BITS; i++) begin
      @(negedge aclk);
      for (int k = 0; k < LANES; k++) w[k*BITS + BITS-1-i] = ser_d[k];
    end
  endtask

  // ---------------- stimulus ----------------
  logic [11:0]  pat0, pat1;
  logic [W-1:0] frame_w;
  logic [31:0]  fc_before;

  initial begin
    aresetn = 1'b0; en = 1'b0; mode = 2'd0; sync_req = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    cmp_en  = 1'b1;

    // Reset values
    @(negedge aclk);
    chk("rst_ser_d",     ser_d,     0);
    chk("rst_ser_fclk",  ser_fclk,  0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_underrun",  underrun,  0);
    chk("rst_s_tready",  s_tready,  0);

    // Stream: lane0 = ABC, lane1 = 123, three gapless frames
    drive_edge();
    en = 1'b1; mode = 2'd0; s_tvalid = 1'b1;
    s_tdata = {$urandom, $urandom, $urandom};
    s_tdata[11:0]  = 12'hABC;
    s_tdata[23:12] = 12'h123;
    pat0 = 12'hABC;
    pat1 = 12'h123;
    @(negedge aclk);
    chk("t1_tready_en", s_tready, 1);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < BITS; i++) begin
        @(negedge aclk);
        chk("t1_lane0", ser_d[0], pat0[11-i]);
        chk("t1_lane1", ser_d[1], pat1[11-i]);
        chk("t1_fclk",  ser_fclk, (i < 6) ? 1 : 0);
        chk("t1_tready", s_tready, (i == 11) ? 1 : 0);
        if (i == 0) chk("t1_frame_cnt", frame_cnt, f + 1);
      end
    end

    // Underrun via a sync load with no valid word
    drive_edge();
    s_tvalid = 1'b0; sync_req = 1'b1;
    @(negedge aclk);
    chk("t3_tready_sync", s_tready, 1);
    drive_edge();
    sync_req = 1'b0;
    @(negedge aclk);
    chk("t3_underrun_set", underrun, 1);
    chk("t3_idle_msb",     ser_d,    8'hFF);
    drive_edge();
    sync_req = 1'b1; underrun_clr = 1'b1;
    drive_edge();
    sync_req = 1'b0; underrun_clr = 1'b0; s_tvalid = 1'b1;
    @(negedge aclk);
    chk("t3_set_wins", underrun, 1);
    drive_edge();
    underrun_clr = 1'b1;
    drive_edge();
    underrun_clr = 1'b0;
    @(negedge aclk);
    chk("t3_clear", underrun, 0);

    // sync_req at bit 5: word consumed in the sync cycle, new MSB next cycle
    wait_pos(5);
    fc_before = m_frames;
    s_tdata = {$urandom, $urandom, $urandom};
    s_tdata[11:0] = 12'h35A;
    sync_req = 1'b1;
    @(negedge aclk);
    chk("t5_tready_sync", s_tready, 1);
    drive_edge();
    sync_req = 1'b0;
    @(negedge aclk);
    chk("t5_new_msb",   ser_d[0],  0);
    chk("t5_fclk",      ser_fclk,  1);
    chk("t5_frame_inc", frame_cnt, fc_before + 32'd1);

    // en dropped at bit 7
    wait_pos(7);
    en = 1'b0;
    @(negedge aclk);
    chk("t6_tready_off", s_tready, 0);
    @(negedge aclk);
    chk("t6_ser_d_off", ser_d,    0);
    chk("t6_fclk_off",  ser_fclk, 0);
    repeat (3) @(negedge aclk);
    chk("t6_tready_idle", s_tready, 0);

    // Reset mid-frame: outputs clear immediately, nothing consumed
    drive_edge();
    en = 1'b1;
    wait_pos(4);
    aresetn = 1'b0;
    mode    = 2'd2;
    #1;
    chk("t7_ser_d",     ser_d,     0);
    chk("t7_fclk",      ser_fclk,  0);
    chk("t7_frame_cnt", frame_cnt, 0);
    chk("t7_tready",    s_tready,  0);
    chk("t7_underrun",  underrun,  0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Ramp: 4097 frames from a fresh reset
    collect(frame_w);
    chk("t4_ramp_f0_l3", frame_w[3*BITS +: BITS], 3);
    chk("t4_ramp_f0_l7", frame_w[7*BITS +: BITS], 7);
    repeat (4095 * BITS) @(negedge aclk);
    collect(frame_w);
    chk("t4_ramp_f4096_l0", frame_w[0 +: BITS],      0);
    chk("t4_ramp_f4096_l5", frame_w[5*BITS +: BITS], 5);
    chk("t4_frame_cnt",     frame_cnt,               4097);

    // Reserved mode behaves as fixed pattern
    drive_edge();
    mode = 2'd3; sync_req = 1'b1;
    @(negedge aclk);
    chk("t8_tready_rsvd", s_tready, 0);
    drive_edge();
    sync_req = 1'b0;
    collect(frame_w);
    chk("t8_fixed_l2", frame_w[2*BITS +: BITS], 12'hA5C);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      drive_edge();
      en           = ($urandom_range(0, 31) != 0);
      sync_req     = ($urandom_range(0, 19) == 0);
      s_tvalid     = ($urandom_range(0, 7) != 0);
      s_tdata      = {$urandom, $urandom, $urandom};
      underrun_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) begin
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
      end
    end

    drive_edge();
    en = 1'b0;
    repeat (2) @(negedge aclk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_serial_tx.md
Name: adc_serial_tx

Overview:
- Transmit-side counterpart of the board's multi-lane serial ADC capture path (adc_d lanes + frame clock): serializes parallel sample words onto LANES single-ended serial lanes with an aligned frame clock.
- Used as an on-chip ADC emulator for loopback/bring-up of the deserializer and the DMA path without the physical converter.
- Sample source is an AXI-Stream-style slave, a fixed pattern or a per-frame ramp.
- One serial bit per aclk cycle (SDR); the bit clock equals aclk.

Parameters:
LANES, 8, number of serial data lanes (one channel per lane)
BITS, 12, bits per sample per frame (>=4, even)
IDLE_WORD, 12'h800, per-lane word sent on underrun (mid-scale)
FIXED_WORD, 12'hA5C, per-lane word in fixed-pattern mode

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
en  in  1  transmitter enable
mode  in  2  0=stream, 1=fixed pattern, 2=ramp, 3=reserved (treated as 1)
sync_req  in  1  one-cycle pulse: restart frame alignment
s_tdata  in  LANES*BITS  lane k uses bits [k*BITS +: BITS]
s_tvalid  in  1  stream word valid
s_tready  out  1  stream word accepted this cycle (combinational)
ser_d  out  LANES  serial data, MSB first, registered
ser_fclk  out  1  frame clock, registered, aligned with ser_d
frame_cnt  out  32  frames started since reset, wraps
underrun  out  1  sticky: stream mode frame started with s_tvalid=0
underrun_clr  in  1  clears underrun

Behaviour:
- Reset: state IDLE; ser_d=0, ser_fclk=0, s_tready=0, frame_cnt=0, underrun=0, bit_cnt=0, ramp=0.
- States: IDLE, RUN.
- load = en && (state==IDLE || (state==RUN && bit_cnt==BITS-1) || sync_req).
- On load: per-lane shift reg <= selected word; bit_cnt <= 0; state <= RUN; frame_cnt++. ser_d <= word MSBs; ser_fclk <= 1.
- Word select is sampled at load only; mode changes mid-frame take effect next frame:
  - stream: s_tdata if s_tvalid, else IDLE_WORD on every lane and underrun <= 1.
  - fixed: FIXED_WORD on every lane.
  - ramp: lane k = (ramp + k) mod 2^BITS; ramp++ after each ramp-frame load, wrapping at 2^BITS.
- s_tready = load && mode==0. Handshake: a word is consumed iff s_tvalid && s_tready. Latency: accepted at cycle t, MSB on ser_d at t+1, LSB at t+BITS.
- RUN, non-load cycle: bit_cnt++, shift left, ser_d = bit (BITS-1-bit_cnt) of each lane word. ser_fclk = 1 while bit_cnt < BITS/2, else 0.
- Frames are back-to-back with no gap: the LSB cycle of frame n is the load cycle of frame n+1.
- sync_req in RUN with en: current frame is abandoned mid-word and a new frame loads in that same cycle. sync_req with en=0 is ignored.
- en deasserted: next cycle state=IDLE, ser_d=0, ser_fclk=0, bit_cnt=0. The partial frame is dropped and s_tready stays 0.
- underrun: underrun_clr clears it. If set and clear occur in the same cycle, set wins.
- aresetn asserted mid-frame: immediate return to reset values; no word is consumed.

Decomposition:
- Package adc_serial_pkg:
  - mode enum (MODE_STREAM, MODE_FIXED, MODE_RAMP)
  - default BITS/LANES constants
  - IDLE_WORD / FIXED_WORD defaults
  - FCLK high-length constant (BITS/2)
- Sub-module adc_lane_serializer: one lane's BITS-wide parallel-load MSB-first shift register with a load input; instantiated LANES times via generate.
- FSM, counters and word select stay in the top module.

Test Plan:
- Reset, then en=1, mode=0, s_tvalid=1, lane0=12'hABC, lane1=12'h123 -> s_tready=1 on the en cycle only. From the next cycle, ser_d[0] = 1,0,1,0,1,0,1,1,1,1,0,0 and ser_d[1] = 0,0,0,1,0,0,1,0,0,0,1,1. ser_fclk=1 for 6 cycles then 0 for 6. frame_cnt=1.
- Continuous s_tvalid over 3 frames -> s_tready pulses every 12 cycles; frames are gapless; frame_cnt=3 after the third load.
- Stream mode with s_tvalid=0 at a frame boundary -> all lanes send 12'h800, underrun=1. Pulse underrun_clr together with a second underrun in the same cycle -> underrun stays 1. Clear alone -> 0.
- mode=2 for 4097 frames -> lane3 in frame 0 = 3. Ramp wraps after frame 4095: lane0 in frame 4096 = 0.
- sync_req at bit_cnt=5 -> new frame MSB appears the next cycle with ser_fclk=1; frame_cnt increments; in stream mode the word is consumed in the sync cycle.
- en=0 at bit_cnt=7, then aresetn pulse mid-frame -> outputs 0 the next cycle (en case) and immediately (reset case); frame_cnt=0 after reset; no s_tready pulse.
